// File: rtl/dmem_banked.sv
// Banked scalar/vector data memory: N_LANES element banks behind one element-addressed port.
// Define DMEM_UNALIGNED_EN to serve unaligned vector accesses with a two-row sequence.
module dmem_banked #(
  parameter int N_LANES = 16,
  parameter int LANE_W  = 16,
  parameter int DEPTH   = 2048
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       w_enable,
  input  logic                       src_sel,
  input  logic [31:0]                addr,
  input  logic [LANE_W-1:0]          w_data_a,
  input  logic [N_LANES*LANE_W-1:0]  w_data_b,
  output logic                       resp_valid,
  output logic [LANE_W-1:0]          q_a,
  output logic [N_LANES*LANE_W-1:0]  q_b,
  output logic                       err
);
  localparam int OFF_W = $clog2(N_LANES);
  localparam int ROW_W = $clog2(DEPTH);
  localparam int VEC_W = N_LANES * LANE_W;
  localparam logic [32:0] CAP = 33'(DEPTH) * 33'(N_LANES);

  typedef enum logic [1:0] {IDLE, ROW0, ROW1, RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d, vec_q, vec_d, bad_q, bad_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [LANE_W-1:0]   wa_q, wa_d;
  logic [VEC_W-1:0]    wb_q, wb_d;
  logic                resp_valid_q, resp_valid_d, err_q, err_d;
  logic [LANE_W-1:0]   q_a_q, q_a_d;
  logic [VEC_W-1:0]    q_b_q, q_b_d;
  logic                accept, illegal;
  logic [32:0]         addr_ext;

  logic                bank_en    [N_LANES];
  logic [ROW_W-1:0]    bank_row   [N_LANES];
  logic [LANE_W-1:0]   bank_wdata [N_LANES];
  logic [OFF_W-1:0]    elem_idx   [N_LANES];
  logic [OFF_W-1:0]    rot_idx    [N_LANES];
  logic [LANE_W-1:0]   rd_bank    [N_LANES];

  assign accept = req_valid && req_ready;

  // Range check uses 33 bits so addr + N_LANES cannot wrap back into range.
  always_comb begin
    addr_ext = {1'b0, addr};
    if (src_sel) illegal = (addr_ext + 33'(N_LANES)) > CAP;
    else         illegal = addr_ext >= CAP;
`ifndef DMEM_UNALIGNED_EN
    if (src_sel && (addr[OFF_W-1:0] != '0)) illegal = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      vec_q        <= 1'b0;
      bad_q        <= 1'b0;
      off_q        <= '0;
      row_q        <= '0;
      wa_q         <= '0;
      wb_q         <= '0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      q_a_q        <= '0;
      q_b_q        <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      vec_q        <= vec_d;
      bad_q        <= bad_d;
      off_q        <= off_d;
      row_q        <= row_d;
      wa_q         <= wa_d;
      wb_q         <= wb_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      q_a_q        <= q_a_d;
      q_b_q        <= q_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    vec_d   = vec_q;
    bad_d   = bad_q;
    off_d   = off_q;
    row_d   = row_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    case (state_q)
      IDLE: if (accept) begin
        we_d    = w_enable;
        vec_d   = src_sel;
        bad_d   = illegal;
        off_d   = addr[OFF_W-1:0];
        row_d   = addr[OFF_W +: ROW_W];
        wa_d    = w_data_a;
        wb_d    = w_data_b;
        state_d = illegal ? RESP : ROW0;
      end
`ifdef DMEM_UNALIGNED_EN
      ROW0:    state_d = (vec_q && (off_q != '0)) ? ROW1 : RESP;
      ROW1:    state_d = RESP;
`else
      ROW0:    state_d = RESP;
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bank b carries element (b - offset) mod N_LANES; ROW0 serves banks >= offset, ROW1 the rest.
  always_comb begin
    for (int b = 0; b < N_LANES; b++) begin
      elem_idx[b]   = OFF_W'(b) - off_q;
      bank_en[b]    = 1'b0;
      bank_row[b]   = row_q;
      bank_wdata[b] = vec_q ? wb_q[int'(elem_idx[b])*LANE_W +: LANE_W] : wa_q;
      case (state_q)
        ROW0: bank_en[b] = vec_q ? (OFF_W'(b) >= off_q) : (OFF_W'(b) == off_q);
`ifdef DMEM_UNALIGNED_EN
        ROW1: begin
          bank_en[b]  = OFF_W'(b) < off_q;
          bank_row[b] = row_q + 1'b1;
        end
`endif
        default: bank_en[b] = 1'b0;
      endcase
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_bank
    logic [LANE_W-1:0] mem [DEPTH];
    logic [LANE_W-1:0] rd_data;
    // Writes are suppressed on a reset edge so a pending ROW1 write is dropped.
    always_ff @(posedge clk) begin
      if (bank_en[g]) begin
        if (we_q) begin
          if (!rst) mem[bank_row[g]] <= bank_wdata[g];
        end else begin
          rd_data <= mem[bank_row[g]];
        end
      end
    end
    assign rd_bank[g] = rd_data;
  end

  always_comb begin
    resp_valid_d = (state_q == RESP);
    err_d        = (state_q == RESP) && bad_q;
    q_a_d        = q_a_q;
    q_b_d        = q_b_q;
    for (int i = 0; i < N_LANES; i++) rot_idx[i] = OFF_W'(i) + off_q;
    if ((state_q == RESP) && !bad_q && !we_q) begin
      if (vec_q) begin
        for (int i = 0; i < N_LANES; i++) q_b_d[i*LANE_W +: LANE_W] = rd_bank[rot_idx[i]];
      end else begin
        q_a_d = rd_bank[off_q];
      end
    end
  end

  always_comb begin
    req_ready  = (state_q == IDLE) && !resp_valid_q;
    resp_valid = resp_valid_q;
    err        = err_q;
    q_a        = q_a_q;
    q_b        = q_b_q;
  end
endmodule
